// File: rtl/tmds_dc_balance.sv
// TMDS 8b/10b encoder back end for one channel: registers the transition-minimised
// word, applies running-disparity DC balancing and substitutes control symbols in blanking.

package tmds_pkg;
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, v[i]};
        end
        return cnt;
    endfunction
endpackage

module tm_choice (
    input  logic [7:0] data_in,
    output logic [8:0] q_m_out
);
    import tmds_pkg::*;

    logic [3:0] ones_s;
    logic       use_xnor_s;
    logic [8:0] q_m_s;

    // XNOR chaining is chosen when it gives fewer transitions; q_m[8] records XOR (1) vs XNOR (0)
    always_comb begin
        ones_s     = popcount8(data_in);
        use_xnor_s = (ones_s > 4'd4) || ((ones_s == 4'd4) && (data_in[0] == 1'b0));
        q_m_s      = 9'd0;
        q_m_s[0]   = data_in[0];
        for (int i = 1; i < 8; i++) begin
            if (use_xnor_s) begin
                q_m_s[i] = ~(q_m_s[i-1] ^ data_in[i]);
            end else begin
                q_m_s[i] = q_m_s[i-1] ^ data_in[i];
            end
        end
        q_m_s[8] = ~use_xnor_s;
    end

    assign q_m_out = q_m_s;
endmodule

module tmds_dc_balance #(
    parameter int TALLY_W = 5
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [7:0]                data_in,
    input  logic [1:0]                control_in,
    input  logic                      ve_in,
    output logic [9:0]                tmds_out,
    output logic signed [TALLY_W-1:0] tally_out
);
    import tmds_pkg::*;

    localparam logic signed [TALLY_W-1:0] EIGHT = TALLY_W'(4'd8);
    localparam logic signed [TALLY_W-1:0] TWO   = TALLY_W'(2'd2);
    localparam logic signed [TALLY_W-1:0] ZERO  = {TALLY_W{1'b0}};

    logic [8:0]                q_m_s;
    logic [8:0]                q_m_r;
    logic                      ve_r;
    logic [1:0]                control_r;
    logic [9:0]                tmds_r;
    logic [9:0]                tmds_nxt_s;
    logic signed [TALLY_W-1:0] tally_r;
    logic signed [TALLY_W-1:0] tally_nxt_s;
    logic signed [TALLY_W-1:0] diff_s;
    logic [3:0]                n1_s;
    logic                      tally_pos_s;
    logic                      tally_neg_s;
    logic                      diff_pos_s;
    logic                      diff_neg_s;

    tm_choice u_tm_choice (
        .data_in (data_in),
        .q_m_out (q_m_s)
    );

    // Stage 1: capture q_m with its matching video-enable and control bits
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            q_m_r     <= 9'd0;
            ve_r      <= 1'b0;
            control_r <= 2'b00;
        end else begin
            q_m_r     <= q_m_s;
            ve_r      <= ve_in;
            control_r <= control_in;
        end
    end

    // Stage 2 next-state: diff_s is n1 - n0 = 2*n1 - 8 of the stage-1 data bits
    always_comb begin
        tmds_nxt_s  = 10'd0;
        tally_nxt_s = ZERO;
        n1_s        = popcount8(q_m_r[7:0]);
        diff_s      = TALLY_W'({n1_s, 1'b0}) - EIGHT;
        tally_pos_s = !tally_r[TALLY_W-1] && (tally_r != ZERO);
        tally_neg_s = tally_r[TALLY_W-1];
        diff_pos_s  = !diff_s[TALLY_W-1] && (diff_s != ZERO);
        diff_neg_s  = diff_s[TALLY_W-1];
        if (!ve_r) begin
            case (control_r)
                2'b00:   tmds_nxt_s = 10'b1101010100;
                2'b01:   tmds_nxt_s = 10'b0010101011;
                2'b10:   tmds_nxt_s = 10'b0101010100;
                2'b11:   tmds_nxt_s = 10'b1010101011;
                default: tmds_nxt_s = 10'b1101010100;
            endcase
            tally_nxt_s = ZERO;
        end else if ((tally_r == ZERO) || (diff_s == ZERO)) begin
            tmds_nxt_s  = {~q_m_r[8], q_m_r[8], (q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0])};
            tally_nxt_s = q_m_r[8] ? (tally_r + diff_s) : (tally_r - diff_s);
        end else if ((tally_pos_s && diff_pos_s) || (tally_neg_s && diff_neg_s)) begin
            tmds_nxt_s  = {1'b1, q_m_r[8], ~q_m_r[7:0]};
            tally_nxt_s = tally_r + (q_m_r[8] ? TWO : ZERO) - diff_s;
        end else begin
            tmds_nxt_s  = {1'b0, q_m_r[8], q_m_r[7:0]};
            tally_nxt_s = tally_r + diff_s - (q_m_r[8] ? ZERO : TWO);
        end
    end

    // Stage 2 registers: symbol and running disparity update on the same edge
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tmds_r  <= 10'd0;
            tally_r <= ZERO;
        end else begin
            tmds_r  <= tmds_nxt_s;
            tally_r <= tally_nxt_s;
        end
    end

    assign tmds_out  = tmds_r;
    assign tally_out = tally_r;
endmodule

// File: doc/tmds_dc_balance.md
Name: tmds_dc_balance

Overview:
- Completes TMDS 8b/10b encoding for one HDMI/DVI channel.
- Instantiates the existing transition-minimisation stage (tm_choice: 8-bit data in, 9-bit q_m out) and registers its q_m.
- Applies DC balancing against a running disparity tally and emits the 10-bit symbol.
- Substitutes fixed control symbols during blanking.
- Feeds the serialiser; one instance per colour channel, all in the pixel clock domain.

Parameters:
- TALLY_W, 5, width of the signed running-disparity register; must be ≥5.

Ports:
- clk_in  input  1  pixel clock; all state updates on rising edge
- rst_n_in  input  1  asynchronous active-low reset
- data_in  input  8  pixel byte, sampled every cycle
- control_in  input  2  {C1,C0} control bits, sampled every cycle
- ve_in  input  1  video enable; 1 = data period, 0 = control period
- tmds_out  output  10  encoded symbol, registered
- tally_out  output  TALLY_W  current running disparity (signed), registered, debug only

Behaviour:
- Reset: asynchronous on rst_n_in low.
  - All pipeline registers clear: tmds_out=10'b0, tally_out=0, stage-1 q_m=0, stage-1 ve=0, stage-1 control=0.
  - Reset may assert mid-stream; it takes effect immediately.
  - The first symbol after release is computed from inputs sampled at or after the first rising edge with rst_n_in high.
- Stage 1 (edge k):
  - Register q_m = tm_choice(data_in).
  - Register ve_in and control_in alongside q_m, unchanged.
- Stage 2 (edge k+1): compute from the stage-1 registers.
  - n1 = popcount(q_m[7:0]); n0 = 8 - n1.
  - Arithmetic is signed, TALLY_W bits. In valid TMDS streams the tally stays within ±8, so no saturation is needed.
- Latency: inputs sampled at edge k appear on tmds_out after edge k+1, i.e. 2 cycles. Throughput is 1 symbol per cycle, no stalls.
- Control period (stage-1 ve=0):
  - tmds_out by control:
    - 00 → 1101010100
    - 01 → 0010101011
    - 10 → 0101010100
    - 11 → 1010101011
  - tally ← 0.
- Data period, case A (tally==0 or n1==n0):
  - out[9] = ~q_m[8]; out[8] = q_m[8].
  - out[7:0] = q_m[8] ? q_m[7:0] : ~q_m[7:0].
  - tally += q_m[8] ? (n1-n0) : (n0-n1).
- Data period, case B ((tally>0 and n1>n0) or (tally<0 and n0>n1)):
  - out = {1, q_m[8], ~q_m[7:0]}.
  - tally += 2·q_m[8] + (n0-n1).
- Data period, case C (otherwise):
  - out = {0, q_m[8], q_m[7:0]}.
  - tally += (n1-n0) - 2·(~q_m[8]).
- Tally usage: each case reads the tally as it stood before the current edge; the update and tmds_out are written on the same edge.
- tally_out always equals the tally register.
- Control↔data transitions need no special handling beyond the per-cycle rules above. The first data symbol after blanking always starts from tally 0.

Test Plan:
- Reset: hold rst_n_in=0 while driving arbitrary inputs → tmds_out=0 and tally_out=0 throughout. Assert reset asynchronously mid-stream → both clear before the next edge.
- Control codes: ve_in=0, control_in=00, then 01, 10, 11 → tmds_out two cycles later is 1101010100, 0010101011, 0101010100, 1010101011; tally_out stays 0.
- Single data symbol from tally 0: ve_in=1, data_in=0x00 → q_m=1_00000000, tmds_out=0100000000, tally_out=-8.
- Repeated 0xFF from tally 0: first symbol → tmds_out=1000000000, tally=-8. Second symbol (case C) → tmds_out=0011111111, tally=-2.
- Blanking resets tally: after the two 0xFF symbols, one cycle ve_in=0 → tally_out=0. Next 0xFF → 1000000000 again.
- Random regression: 10k cycles of random data_in/ve_in/control_in compared against a software TMDS reference model.
  - tmds_out must match exactly at latency 2.
  - tally_out must remain within -8..+8.
  - In data-only runs, running DC disparity of the output must stay bounded.
